// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for a 64-bit combinational ALU: operand fetch from a
// small register file, ALU drive, result/flag capture, writeback and fault tracking.
module alu_exec_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [2:0]      in_rd,
  input  logic [2:0]      in_rs1,
  input  logic [2:0]      in_rs2,
  input  logic            ld_en,
  input  logic [2:0]      ld_addr,
  input  logic [XLEN-1:0] ld_data,
  input  logic [2:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  input  logic [XLEN-1:0] alu_c,
  input  logic            alu_fz,
  input  logic            alu_fc,
  input  logic            alu_fn,
  input  logic            alu_fv,
  output logic [3:0]      flags,
  output logic            done,
  output logic            err,
  input  logic            err_clr,
  output logic            busy
);

  localparam int unsigned NREG = 8;
  localparam logic [2:0]  OP_DIV = 3'd3;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t          state;
  logic [XLEN-1:0] rf [NREG];
  logic [XLEN-1:0] res_q;
  logic [3:0]      flg_q;
  logic            fault_q;
  logic [2:0]      rd_q;

  // r0 is never written, but mask it anyway so the read is zero by construction
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : rf[dbg_addr];

  // Later assignments in this block take priority: WB write over the load port,
  // fault set over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      flags    <= 4'd0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= 3'd0;
      res_q    <= '0;
      flg_q    <= 4'd0;
      fault_q  <= 1'b0;
      rd_q     <= 3'd0;
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else begin
      done <= 1'b0;
      if (err_clr) err <= 1'b0;
      if (ld_en && ld_addr != 3'd0) rf[ld_addr] <= ld_data;

      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_op   <= in_op;
            rd_q     <= in_rd;
            alu_a    <= (in_rs1 == 3'd0) ? '0 : rf[in_rs1];
            alu_b    <= (in_rs2 == 3'd0) ? '0 : rf[in_rs2];
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= alu_c;
          flg_q   <= {alu_fz, alu_fc, alu_fn, alu_fv};
          fault_q <= (alu_op > OP_DIV) || (alu_op == OP_DIV && alu_b == '0);
          done    <= 1'b1;
          state   <= WB;
        end
        WB: begin
          if (fault_q) begin
            err <= 1'b1;
          end else begin
            flags <= flg_q;
            if (rd_q != 3'd0) rf[rd_q] <= res_q;
          end
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: plays the ALU, tracks architectural state in a
// register-array model and checks every transaction with immediate assertions.
module tb_alu_exec_ctrl;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op, in_rd, in_rs1, in_rs2;
  logic            ld_en;
  logic [2:0]      ld_addr;
  logic [XLEN-1:0] ld_data;
  logic [2:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;
  logic [XLEN-1:0] alu_a, alu_b, alu_c;
  logic [2:0]      alu_op;
  logic            alu_fz, alu_fc, alu_fn, alu_fv;
  logic [3:0]      flags;
  logic            done, err, err_clr, busy;

  int n_chk = 0;
  int n_fail = 0;

  logic [XLEN-1:0] m_rf [8];
  logic [3:0]      m_flags;
  logic            m_err;

  alu_exec_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .alu_fz(alu_fz), .alu_fc(alu_fc), .alu_fn(alu_fn), .alu_fv(alu_fv),
    .flags(flags), .done(done), .err(err), .err_clr(err_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: result and {Z,C,N,V}
  function automatic logic [XLEN+3:0] alu_ref(input logic [2:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [XLEN:0]   s;
    logic [XLEN-1:0] c;
    logic            fc, fv;
    c  = a ^ b;
    fc = 1'b0;
    fv = 1'b0;
    case (op)
      3'd0: begin
        s  = {1'b0, a} + {1'b0, b};
        c  = s[XLEN-1:0];
        fc = s[XLEN];
        fv = (a[XLEN-1] == b[XLEN-1]) && (c[XLEN-1] != a[XLEN-1]);
      end
      3'd1: begin
        c  = a - b;
        fc = (a < b);
        fv = (a[XLEN-1] != b[XLEN-1]) && (c[XLEN-1] != a[XLEN-1]);
      end
      3'd2: c = a * b;
      3'd3: c = (b == '0) ? '1 : a / b;
      default: ;
    endcase
    return {c, (c == '0), fc, c[XLEN-1], fv};
  endfunction

  assign {alu_c, alu_fz, alu_fc, alu_fn, alu_fv} = alu_ref(alu_op, alu_a, alu_b);

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string tag, input logic [2:0] addr);
    dbg_addr = addr;
    #1;
    chk(tag, dbg_data, (addr == 3'd0) ? '0 : m_rf[addr]);
  endtask

  task automatic load(input logic [2:0] addr, input logic [XLEN-1:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    tick();
    ld_en = 1'b0;
    if (addr != 3'd0) m_rf[addr] = data;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err = 1'b0;
    chk("err_clr", 64'(err), 64'(m_err));
  endtask

  // ld_ph: 0 no load, 1 load on the accepting edge, 2 load during WB
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input int ld_ph, input logic [2:0] la,
                       input logic [XLEN-1:0] ld, input bit clr);
    logic [XLEN-1:0] a, b, c;
    logic [3:0]      f;
    bit              fault;
    a = (rs1 == 3'd0) ? '0 : m_rf[rs1];
    b = (rs2 == 3'd0) ? '0 : m_rf[rs2];
    {c, f} = alu_ref(op, a, b);
    fault = (op > 3'd3) || (op == 3'd3 && b == '0);

    chk("idle_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    if (ld_ph == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = ld; end
    tick();
    in_valid = 1'b0; ld_en = 1'b0;
    in_op = 3'($urandom); in_rd = 3'($urandom); in_rs1 = 3'($urandom); in_rs2 = 3'($urandom);
    if (ld_ph == 1 && la != 3'd0) m_rf[la] = ld;
    chk("exec_busy", 64'(busy), 64'd1);
    chk("exec_ready", 64'(in_ready), 64'd0);
    chk("exec_done", 64'(done), 64'd0);
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_alu_op", 64'(alu_op), 64'(op));
    tick();
    chk("wb_done", 64'(done), 64'd1);
    chk("wb_busy", 64'(busy), 64'd1);
    if (ld_ph == 2) begin ld_en = 1'b1; ld_addr = la; ld_data = ld; end
    err_clr = clr;
    tick();
    ld_en = 1'b0; err_clr = 1'b0;
    if (ld_ph == 2 && la != 3'd0) m_rf[la] = ld;
    if (!fault && rd != 3'd0) m_rf[rd] = c;
    if (!fault) m_flags = f;
    if (clr) m_err = 1'b0;
    if (fault) m_err = 1'b1;
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("hold_alu_a", alu_a, a);
    chk("flags", 64'(flags), 64'(m_flags));
    chk("err", 64'(err), 64'(m_err));
    peek("rd_val", rd);
    if (ld_ph != 0) peek("ld_val", la);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] v;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_rd = 3'd0; in_rs1 = 3'd0; in_rs2 = 3'd0;
    ld_en = 1'b0; ld_addr = 3'd0; ld_data = '0; dbg_addr = 3'd0; err_clr = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_flags = 4'd0; m_err = 1'b0;
    #23;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_alu_a", alu_a, '0);
    chk("rst_alu_b", alu_b, '0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Directed plan
    load(3'd1, 64'd5); load(3'd2, 64'd7);
    issue(3'd0, 3'd3, 3'd1, 3'd2, 0, 3'd0, '0, 1'b0);
    chk("add_r3", m_rf[3] == 64'd12 ? dbg_data : '1, 64'd12);
    load(3'd1, 64'h10); load(3'd2, 64'h10);
    issue(3'd1, 3'd4, 3'd1, 3'd2, 0, 3'd0, '0, 1'b0);
    chk("sub_z", 64'(flags[3]), 64'd1);
    issue(3'd3, 3'd5, 3'd1, 3'd0, 0, 3'd0, '0, 1'b0);
    clear_err();
    issue(3'd5, 3'd6, 3'd1, 3'd2, 0, 3'd0, '0, 1'b0);
    issue(3'd5, 3'd6, 3'd1, 3'd2, 0, 3'd0, '0, 1'b1);
    clear_err();
    issue(3'd0, 3'd0, 3'd1, 3'd2, 0, 3'd0, '0, 1'b0);
    issue(3'd0, 3'd3, 3'd1, 3'd2, 2, 3'd3, 64'hFF, 1'b0);
    issue(3'd0, 3'd5, 3'd1, 3'd2, 1, 3'd1, 64'd100, 1'b0);
    issue(3'd2, 3'd7, 3'd1, 3'd5, 2, 3'd2, 64'd3, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        v = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
        load(3'($urandom), v);
      end
      issue(($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3)),
            3'($urandom), 3'($urandom), 3'($urandom), $urandom_range(0, 2),
            3'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
      if (err && $urandom_range(0, 1) == 0) clear_err();
    end

    // Reset during EXEC
    chk("pre_rst_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = 3'd0; in_rd = 3'd6; in_rs1 = 3'd1; in_rs2 = 3'd2;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_flags = 4'd0; m_err = 1'b0;
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_flags", 64'(flags), 64'd0);
    chk("mid_rst_alu_a", alu_a, '0);
    chk("mid_rst_alu_op", 64'(alu_op), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_done", 64'(done), 64'd0);
    end
    peek("post_rst_r6", 3'd6);
    peek("post_rst_r1", 3'd1);
    load(3'd1, 64'd40); load(3'd2, 64'd2);
    issue(3'd3, 3'd6, 3'd1, 3'd2, 0, 3'd0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execute-stage sequencer that sits directly upstream of the 64-bit combinational ALU and consumes its result and flags. It accepts register-to-register instructions over a valid/ready handshake, reads operands from an internal register file, drives the ALU operand and opcode lines, captures the ALU result and Z/C/N/V flags, and writes them back. It also detects illegal opcodes and divide-by-zero, and suppresses writeback for both.

## Interface
- XLEN, 64, datapath width.
- NREG, 8, register count; register address width is 3 bits; r0 reads as zero.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept an instruction.
- in_op  in  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4–7 illegal.
- in_rd, in_rs1, in_rs2  in  3 each  destination and source register indices.
- ld_en  in  1  external register load strobe.
- ld_addr  in  3  load index.
- ld_data  in  XLEN  load data.
- dbg_addr  in  3  debug read index.
- dbg_data  out  XLEN  combinational read of rf[dbg_addr]; returns 0 for r0.
- alu_a, alu_b  out  XLEN  ALU operands.
- alu_op  out  3  ALU opcode.
- alu_c  in  XLEN  ALU result.
- alu_fz, alu_fc, alu_fn, alu_fv  in  1 each  ALU flags.
- flags  out  4  architectural status {Z,C,N,V}.
- done  out  1  one-cycle pulse when an instruction retires (including faulted ones).
- err  out  1  sticky fault flag.
- err_clr  in  1  clears err.
- busy  out  1  high in EXEC or WB.

## Operation
- FSM states: IDLE, EXEC, WB. Reset state is IDLE.
- **IDLE:** in_ready=1.
  - When in_valid=1, latch op_q, rd_q, opa_q=rf[in_rs1], opb_q=rf[in_rs2] (reads of r0 yield 0), then go to EXEC.
  - Operand reads see the register contents before any same-cycle ld_en write (read-before-write).
- **EXEC:**
  - alu_a=opa_q, alu_b=opb_q, alu_op=op_q, all driven from registers.
  - At the clock edge ending EXEC: capture res_q=alu_c and flg_q={alu_fz,alu_fc,alu_fn,alu_fv}.
  - Compute fault_q = (op_q>3) | (op_q==3 & opb_q==0).
  - Go to WB.
- **WB:**
  - If fault_q=0: write res_q to rf[rd_q] (unless rd_q==0) and update flags<=flg_q.
  - If fault_q=1: no register write, flags unchanged, err<=1.
  - done=1 in this cycle. Go to IDLE.
- alu_a, alu_b and alu_op hold their last registered values outside EXEC; they never change combinationally with in_*.
- **Load port:** ld_en writes ld_data to rf[ld_addr] in any state. Writes to r0 are ignored. If a WB write targets the same register in the same cycle, the WB write wins.
- **err:**
  - Set by a WB fault, cleared by err_clr.
  - If set and clear happen in the same cycle, set wins.
- Width rules: the result is taken as the low XLEN bits of alu_c. The stage does no arithmetic of its own; flags come only from the ALU.

## Timing
- Reset values: in_ready=1, busy=0, done=0, err=0, flags=0, alu_a=0, alu_b=0, alu_op=0, all registers 0.
- Accept at edge N. EXEC during cycle N+1. WB/done during cycle N+2. The written value is visible on dbg_data from cycle N+3.
- Throughput: one instruction per 3 cycles. in_ready=0 while busy=1, so back-to-back offers wait.
- Back-to-back dependent instructions need no forwarding: the WB write completes before the next IDLE read.
- in_valid may drop without acceptance whenever in_ready=0. Fields are sampled only on the accepting edge.
- Reset mid-operation: immediately returns to IDLE. The pending write is discarded, done stays 0, and the register file is cleared.

## Test plan
- Load r1=5, r2=7. Issue ADD rd=3 → done 2 cycles after acceptance, r3=12, flags Z=0, and C/N/V match the ALU flag inputs.
- Load r1=r2=0x10. Issue SUB rd=4 → r4=0, flags Z=1.
- Issue DIV with rs2=r0 → done pulses, rd unchanged, flags unchanged, err=1. Pulse err_clr → err=0.
- Issue op=5 → no register write, err=1. Assert err_clr in the same cycle as a second fault's WB → err stays 1.
- Issue ADD with rd=0 → dbg_data(0)=0. Drive ld_en to rd_q with 0xFF in the WB cycle → WB result wins.
- Assert rst_n=0 during EXEC → next cycle in_ready=1, done never pulses, all outputs at reset values.
